// File: rtl/uart_dds_cmd_parser.sv
// Command-frame parser between a UART receiver/transmitter pair and a DDS core.
// Define UART_CMD_READBACK_EN to build CMD=04 register readback; otherwise CMD=04 is rejected.
module uart_dds_cmd_parser #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100_000,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rec_flag,
    output logic        rx_clr,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic [31:0] freq_word,
    output logic [11:0] phase_word,
    output logic [11:0] amp_word,
    output logic        freq_upd,
    output logic        phase_upd,
    output logic        amp_upd,
    output logic        frame_err,
    output logic        busy
);

    localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_CSUM,
        S_EXEC,
        S_ACK_START,
        S_ACK_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_take;
    logic [7:0]      r_byte;
    logic [7:0]      r_cmd;
    logic [31:0]     r_data;
    logic [1:0]      r_cnt;
    logic [7:0]      r_sum;
    logic            r_csum_ok;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_tx_done_d;
    logic [7:0]      r_tx_data;
    logic [31:0]     r_freq;
    logic [11:0]     r_phase;
    logic [11:0]     r_amp;

    logic            w_frame_st;
    logic            w_intake_st;
    logic            w_take;
    logic            w_timeout;
    logic            w_done_rise;
    logic            w_cmd_std;
    logic            w_good;
    logic [7:0]      w_reply;
    logic            w_rb_more;
    logic [7:0]      w_rb_next;

    assign w_frame_st  = (r_state == S_CMD) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_intake_st = (r_state == S_IDLE) || w_frame_st;
    // r_take is both the rx_clr pulse and the guard that blocks re-taking while the flag falls.
    assign w_take      = rx_rec_flag && !r_take && w_intake_st;
    assign w_timeout   = w_frame_st && !r_take && (r_to_cnt == TO_LAST);
    assign w_done_rise = tx_done && !r_tx_done_d;
    assign w_cmd_std   = (r_cmd == 8'h01) || (r_cmd == 8'h02) || (r_cmd == 8'h03);

`ifdef UART_CMD_READBACK_EN
    logic        w_rb_cmd;
    logic [31:0] w_rb_sel;
    logic [23:0] r_rb_word;
    logic [1:0]  r_rb_left;

    assign w_rb_cmd = (r_cmd == 8'h04) && (r_data[7:0] <= 8'd2);

    always_comb begin
        w_rb_sel = r_freq;
        case (r_data[1:0])
            2'd1:    w_rb_sel = {20'h0, r_phase};
            2'd2:    w_rb_sel = {20'h0, r_amp};
            default: w_rb_sel = r_freq;
        endcase
    end

    assign w_good    = r_csum_ok && (w_cmd_std || w_rb_cmd);
    assign w_reply   = !w_good ? NAK_BYTE : (w_rb_cmd ? w_rb_sel[31:24] : ACK_BYTE);
    assign w_rb_more = (r_rb_left != 2'd0);
    assign w_rb_next = r_rb_word[23:16];

    // Remaining readback bytes, MSB first; each one is released by a tx_done edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rb_word <= '0;
            r_rb_left <= '0;
        end else if (r_state == S_EXEC && w_good && w_rb_cmd) begin
            r_rb_word <= w_rb_sel[23:0];
            r_rb_left <= 2'd3;
        end else if (r_state == S_ACK_WAIT && w_done_rise && w_rb_more) begin
            r_rb_word <= {r_rb_word[15:0], 8'h00};
            r_rb_left <= r_rb_left - 2'd1;
        end
    end
`else
    assign w_good    = r_csum_ok && w_cmd_std;
    assign w_reply   = w_good ? ACK_BYTE : NAK_BYTE;
    assign w_rb_more = 1'b0;
    assign w_rb_next = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (r_take && r_byte == HEADER) w_state_next = S_CMD;
            S_CMD: begin
                if (r_take)         w_state_next = S_DATA;
                else if (w_timeout) w_state_next = S_IDLE;
            end
            S_DATA: begin
                if (r_take && r_cnt == 2'd3) w_state_next = S_CSUM;
                else if (w_timeout)          w_state_next = S_IDLE;
            end
            S_CSUM: begin
                if (r_take)         w_state_next = S_EXEC;
                else if (w_timeout) w_state_next = S_IDLE;
            end
            S_EXEC:      w_state_next = S_ACK_START;
            S_ACK_START: w_state_next = S_ACK_WAIT;
            S_ACK_WAIT:  if (w_done_rise) w_state_next = w_rb_more ? S_ACK_START : S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_start  = 1'b0;
        freq_upd  = 1'b0;
        phase_upd = 1'b0;
        amp_upd   = 1'b0;
        frame_err = w_timeout;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_EXEC: begin
                freq_upd  = w_good && (r_cmd == 8'h01);
                phase_upd = w_good && (r_cmd == 8'h02);
                amp_upd   = w_good && (r_cmd == 8'h03);
                frame_err = !w_good;
            end
            S_ACK_START: tx_start = 1'b1;
            default: ;
        endcase
    end

    assign rx_clr     = r_take;
    assign tx_data    = r_tx_data;
    assign freq_word  = r_freq;
    assign phase_word = r_phase;
    assign amp_word   = r_amp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_take      <= 1'b0;
            r_byte      <= '0;
            r_cmd       <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_csum_ok   <= 1'b0;
            r_to_cnt    <= '0;
            r_tx_done_d <= 1'b0;
            r_tx_data   <= '0;
            r_freq      <= '0;
            r_phase     <= '0;
            r_amp       <= '0;
        end else begin
            r_take      <= w_take;
            r_tx_done_d <= tx_done;
            if (w_take) r_byte <= rx_data;

            if (w_frame_st && !r_take) r_to_cnt <= r_to_cnt + 1'b1;
            else                       r_to_cnt <= '0;

            case (r_state)
                S_IDLE: if (r_take && r_byte == HEADER) r_sum <= '0;
                S_CMD: begin
                    if (r_take) begin
                        r_cmd <= r_byte;
                        r_sum <= r_sum + r_byte;
                        r_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (r_take) begin
                        r_data <= {r_data[23:0], r_byte};
                        r_sum  <= r_sum + r_byte;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                S_CSUM: if (r_take) r_csum_ok <= (r_byte == r_sum);
                S_EXEC: begin
                    r_tx_data <= w_reply;
                    if (w_good && r_cmd == 8'h01) r_freq  <= r_data;
                    if (w_good && r_cmd == 8'h02) r_phase <= r_data[11:0];
                    if (w_good && r_cmd == 8'h03) r_amp   <= r_data[11:0];
                end
                S_ACK_WAIT: if (w_done_rise && w_rb_more) r_tx_data <= w_rb_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dds_cmd_parser.sv
// Scoreboard bench for uart_dds_cmd_parser: directed frames plus random traffic against a frame-level model.
`timescale 1ns/1ps
module tb_uart_dds_cmd_parser;

    localparam int         TO  = 200;
    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rec_flag = 1'b0;
    logic        rx_clr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic [31:0] freq_word;
    logic [11:0] phase_word;
    logic [11:0] amp_word;
    logic        freq_upd, phase_upd, amp_upd, frame_err, busy;

    always #5 clk = ~clk;

    uart_dds_cmd_parser #(
        .HEADER(HDR), .TIMEOUT_CYCLES(TO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rec_flag(rx_rec_flag), .rx_clr(rx_clr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .freq_word(freq_word), .phase_word(phase_word), .amp_word(amp_word),
        .freq_upd(freq_upd), .phase_upd(phase_upd), .amp_upd(amp_upd),
        .frame_err(frame_err), .busy(busy)
    );

    typedef struct {
        int          kind;   // 1 freq, 2 phase, 3 amp, 4 frame_err
        logic [31:0] val;
    } ev_t;

    int          errors = 0;
    int          checks = 0;
    ev_t         exp_ev[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  frm[$];
    logic [31:0] m_freq = 0;
    logic [11:0] m_phase = 0;
    logic [11:0] m_amp = 0;
    int          n_sent = 0, n_rx_clr = 0, n_tx_start = 0, n_tx_exp = 0;
    int          drv_cnt = 0, drv_hold = 0;
    logic        drv_rst_seen = 1'b0;
    logic [7:0]  drv_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // ---------------- reference model: frames as byte lists ----------------
    task automatic push_tx(input logic [7:0] b);
        exp_tx.push_back(b);
        n_tx_exp++;
    endtask

    task automatic model_frame();
        logic [31:0] d;
        logic [31:0] r;
        logic [7:0]  s;
        logic [7:0]  c;
        bit          ok;
        c  = frm[1];
        d  = {frm[2], frm[3], frm[4], frm[5]};
        s  = frm[1] + frm[2] + frm[3] + frm[4] + frm[5];
        ok = (s == frm[6]);
        r  = 0;
        if (ok && c == 8'h01) begin
            m_freq = d;
            exp_ev.push_back('{1, d});
            push_tx(ACK);
        end else if (ok && c == 8'h02) begin
            m_phase = d[11:0];
            exp_ev.push_back('{2, {20'h0, d[11:0]}});
            push_tx(ACK);
        end else if (ok && c == 8'h03) begin
            m_amp = d[11:0];
            exp_ev.push_back('{3, {20'h0, d[11:0]}});
            push_tx(ACK);
`ifdef UART_CMD_READBACK_EN
        end else if (ok && c == 8'h04 && d[7:0] <= 8'd2) begin
            r = (d[7:0] == 0) ? m_freq : (d[7:0] == 1) ? {20'h0, m_phase} : {20'h0, m_amp};
            for (int i = 3; i >= 0; i--) push_tx(r[i*8 +: 8]);
`endif
        end else begin
            exp_ev.push_back('{4, 0});
            push_tx(NAK);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (frm.size() == 0 && b != HDR) return;
        frm.push_back(b);
        if (frm.size() == 7) begin
            model_frame();
            frm.delete();
        end
    endtask

    task automatic model_timeout();
        if (frm.size() != 0) begin
            exp_ev.push_back('{4, 0});
            frm.delete();
        end
    endtask

    task automatic model_reset();
        frm.delete();
        m_freq  = 0;
        m_phase = 0;
        m_amp   = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic got;
        repeat (gap) @(negedge clk);
        model_byte(b);
        rx_data     = b;
        rx_rec_flag = 1'b1;
        n_sent++;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_clr) begin
                rx_rec_flag = 1'b0;
                got = 1'b1;
                break;
            end
        end
        check("rx_clr_seen", got, 1'b1);
        rx_rec_flag = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d, input bit bad,
                              input int nbytes, input int gap_pos, input int gap_len);
        logic [7:0] fb[7];
        fb[0] = HDR; fb[1] = cmd;
        fb[2] = d[31:24]; fb[3] = d[23:16]; fb[4] = d[15:8]; fb[5] = d[7:0];
        fb[6] = cmd + d[31:24] + d[23:16] + d[15:8] + d[7:0];
        if (bad) fb[6] = fb[6] + 8'($urandom_range(1, 255));
        for (int i = 0; i < nbytes; i++)
            send_byte(fb[i], (i == gap_pos) ? gap_len : int'($urandom_range(0, 3)));
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && drv_cnt == 0 && drv_hold == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        check({tag, "_idle"}, ok, 1'b1);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_freq"}, freq_word, m_freq);
        check({tag, "_phase"}, {20'h0, phase_word}, {20'h0, m_phase});
        check({tag, "_amp"}, {20'h0, amp_word}, {20'h0, m_amp});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {rx_clr, tx_start, freq_upd, phase_upd, amp_upd, frame_err, busy}, 7'd0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_freq0"}, freq_word, 32'h0);
        check({tag, "_ph_amp0"}, {phase_word, amp_word}, 24'h0);
    endtask

    // ---------------- monitor: strobes and register values ----------------
    initial begin
        int          pend;
        logic [31:0] pend_val;
        int          nstb;
        int          got;
        ev_t         e;
        pend = 0;
        pend_val = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 0;
                continue;
            end
            case (pend)
                1: check("freq_word", freq_word, pend_val);
                2: check("phase_word", {20'h0, phase_word}, pend_val);
                3: check("amp_word", {20'h0, amp_word}, pend_val);
                default: ;
            endcase
            pend = 0;
            if (rx_clr) n_rx_clr++;
            nstb = int'(freq_upd) + int'(phase_upd) + int'(amp_upd) + int'(frame_err);
            if (nstb != 0) begin
                got = (nstb > 1) ? 9 : freq_upd ? 1 : phase_upd ? 2 : amp_upd ? 3 : 4;
                if (exp_ev.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: got kind %0d expected none", got);
                end else begin
                    e = exp_ev.pop_front();
                    check("strobe_kind", got, e.kind);
                    if (got == e.kind && got < 4) begin
                        pend = got;
                        pend_val = e.val;
                    end
                end
            end
        end
    end

    // ---------------- transmitter model: checks reply bytes, answers with tx_done ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) drv_rst_seen = 1'b1;
            if (drv_hold > 0) begin
                drv_hold--;
                if (drv_hold == 0) tx_done = 1'b0;
            end
            if (drv_cnt > 0) begin
                if (rst) check("tx_start_before_done", tx_start, 1'b0);
                drv_cnt--;
                if (drv_cnt == 0) begin
                    if (!drv_rst_seen) check("tx_data_held", tx_data, drv_byte);
                    tx_done  = 1'b1;
                    drv_hold = $urandom_range(1, 4);
                end
            end else if (rst && tx_start) begin
                n_tx_start++;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_start_unexpected: got byte %h expected none", tx_data);
                end else begin
                    check("tx_byte", tx_data, exp_tx.pop_front());
                end
                drv_byte     = tx_data;
                drv_rst_seen = 1'b0;
                drv_cnt      = $urandom_range(6, 12);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios then random traffic ----------------
    initial begin
        int         c0;
        logic [7:0] bad_frame[7];
        logic [7:0] junk_seq[8];
        logic [7:0] cmd;
        logic [7:0] jb;
        logic [31:0] d;
        int         sel;

        bad_frame = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h23, 8'h00};
        junk_seq  = '{8'h33, 8'hA5, 8'h03, 8'hA5, 8'h00, 8'h0F, 8'hFF, 8'hB6};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8'h01, 32'h12345678, 1'b0, 7, -1, 0);
        wait_idle("good_freq");
        check("good_freq_value", freq_word, 32'h12345678);
        check_regs("good_freq");

        for (int i = 0; i < 7; i++) send_byte(bad_frame[i], 1);
        wait_idle("bad_csum");
        check("bad_csum_phase", {20'h0, phase_word}, 32'h0);
        check_regs("bad_csum");

        c0 = n_rx_clr;
        for (int i = 0; i < 8; i++) send_byte(junk_seq[i], 0);
        wait_idle("junk");
        check("junk_rx_clr_count", n_rx_clr - c0, 8);
        check("junk_amp", {20'h0, amp_word}, 32'hFFF);
        check_regs("junk");

        c0 = n_tx_start;
        send_frame(8'h01, 32'h12345678, 1'b0, 3, -1, 0);
        model_timeout();
        repeat (TO + 5) @(negedge clk);
        check("timeout_busy", busy, 1'b0);
        check("timeout_no_tx", n_tx_start - c0, 0);
        send_frame(8'h01, 32'h0BADF00D, 1'b0, 7, 4, TO - 5);
        wait_idle("after_timeout");
        check_regs("after_timeout");

`ifdef UART_CMD_READBACK_EN
        send_frame(8'h01, 32'h12345678, 1'b0, 7, -1, 0);
        c0 = n_tx_start;
        send_frame(8'h04, 32'h00000000, 1'b0, 7, -1, 0);
        wait_idle("readback");
        check("readback_tx_count", n_tx_start - c0, 4);
`endif

        send_frame(8'h01, 32'hCAFE0001, 1'b0, 7, -1, 0);
        repeat (3) @(negedge clk);
        check("ackwait_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check_zero("reset_ackwait");
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        c0 = n_tx_start;
        repeat (40) @(negedge clk);
        check("reset_no_tx", n_tx_start - c0, 0);
        check("reset_freq", freq_word, 32'h0);
        wait_idle("reset");

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                jb = 8'($urandom);
                if (jb == HDR) jb = jb ^ 8'h01;
                send_byte(jb, 1);
            end
            sel = $urandom_range(0, 5);
            cmd = (sel < 4) ? 8'(sel + 1) : 8'($urandom);
            d   = $urandom;
            if (cmd == 8'h04) d[7:0] = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 6) == 0) begin
                send_frame(cmd, d, 1'b0, $urandom_range(1, 6), -1, 0);
                model_timeout();
                repeat (TO + 5) @(negedge clk);
            end else begin
                send_frame(cmd, d, $urandom_range(0, 4) == 0, 7, -1, 0);
            end
            if ($urandom_range(0, 1) == 1) wait_idle("rand");
        end
        wait_idle("final");
        check_regs("final");
        check("final_ev_left", exp_ev.size(), 0);
        check("final_tx_left", exp_tx.size(), 0);
        check("final_tx_count", n_tx_start, n_tx_exp);
        check("final_rx_clr_count", n_rx_clr, n_sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
